reg_wr_arbiter: RTL
===================

REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 Parameter: N, default 8, data width of each controlled register.
REQ-002 Parameter: R, default 4, number of requesters and of controlled registers (fixed at 4; address is 2 bits).
REQ-003 clk  input  1  single clock; all state updates on the falling edge, matching the controlled regn instances.
REQ-004 rst  input  1  reset, asynchronous, active-low; resets all state and outputs.
REQ-005 pst_req  input  1  request to preset all controlled registers to all-ones.
REQ-006 req  input  R  per-requester write request, level, held until ack.
REQ-007 req_addr  input  2*R  target register index; requester i uses bits [2i+1:2i].
REQ-008 req_data  input  N*R  write data; requester i uses bits [N*i+N-1:N*i].
REQ-009 gnt  output  R  one-hot grant, high during the WRITE state only.
REQ-010 ack  output  R  one-hot completion pulse, high during the ACK state only.
REQ-011 en  output  R  one-hot load enable to the controlled registers, high during WRITE only.
REQ-012 d  output  N  shared data bus to the controlled registers, valid while en is non-zero.
REQ-013 pst  output  1  preset strobe to all controlled registers, high during PRESET only.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, WRITE, ACK, PRESET; all outputs registered, decoded from state and latched winner/address/data.
REQ-016 IDLE: if pst_req or pst_pend is set -> PRESET, and pst_pend is cleared; else if any req bit is set -> WRITE; else stay in IDLE.
REQ-017 Preset has priority over all writes when both are pending in IDLE.
REQ-018 Winner: the first requester with req high, scanning from rr_ptr upward modulo R.
REQ-019 On the IDLE->WRITE edge: latch the winner index, its req_addr field and its req_data field.
REQ-020 WRITE, one cycle: gnt[winner]=1, en[latched addr]=1, d=latched data; next state ACK.
REQ-021 ACK, one cycle: ack[winner]=1, en=0, gnt=0; rr_ptr <= (winner+1) mod R; next state IDLE.
REQ-022 PRESET, one cycle: pst=1, en=0; next state IDLE; rr_ptr is unchanged.
REQ-023 Latency: req sampled in IDLE at edge k -> gnt/en high from edge k to k+1, ack high from k+1 to k+2; at most one write per 3 cycles.
REQ-024 pst_req asserted while busy sets the sticky pst_pend flag; the preset executes at the next IDLE; multiple assertions while busy collapse into one preset.
REQ-025 A requester dropping req after the IDLE->WRITE edge does not abort the operation; the latched write completes and ack is still issued.
REQ-026 Changes on req_data or req_addr after latching do not affect d or en.
REQ-027 Two requesters targeting the same register are serialized in round-robin order; the last writer's data remains in the register.
REQ-028 At most one bit of en, gnt or ack is high in any cycle; en and pst are never high together.
REQ-029 d holds its last value when en=0; the value of d is don't-care when en=0.

Reset
REQ-030 rst=0 forces immediately, regardless of clk: state=IDLE, rr_ptr=0, pst_pend=0, gnt=0, ack=0, en=0, d=0, pst=0, busy=0.
REQ-031 rst asserted mid-WRITE or mid-PRESET aborts the operation; no ack is issued for it, and the operation is not replayed after reset.
REQ-032 First edge after rst release with req=4'b1111 grants requester 0.

Verification
REQ-033 Single write: req=4'b0100, req_addr field 2 = 2'd3, data field 2 = 8'hA5 -> next cycle gnt=4'b0100, en=4'b1000, d=8'hA5; following cycle ack=4'b0100.
REQ-034 Round-robin: req=4'b1111 held -> grant order 0,1,2,3,0 with 3 cycles between grants and exactly one ack per grant.
REQ-035 Preset priority: pst_req=1 and req=4'b0001 in the same IDLE cycle -> pst=1 for one cycle, then WRITE for requester 0.
REQ-036 Sticky preset: pst_req pulsed twice during WRITE -> exactly one PRESET cycle right after ACK->IDLE.
REQ-037 Reset mid-operation: rst=0 during WRITE -> all outputs 0 at once; after release, idle inputs give busy=0 and no ack.
REQ-038 Early drop: req deasserted in the WRITE cycle -> en/d still as latched and ack still pulses in the next cycle.

Source files
------------

// File: rtl/reg_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_wr_arbiter_if
//  Purpose  : Request/grant/write bus between the requesters, the arbiter and
//             the controlled register bank.
//  Revision : 1.0  initial release
// ============================================================================
interface reg_wr_arbiter_if #(
    parameter int N = 8,
    parameter int R = 4
);
    logic             pst_req;
    logic [R-1:0]     req;
    logic [2*R-1:0]   req_addr;
    logic [N*R-1:0]   req_data;
    logic [R-1:0]     gnt;
    logic [R-1:0]     ack;
    logic [R-1:0]     en;
    logic [N-1:0]     d;
    logic             pst;
    logic             busy;

    // Requester side drives requests and observes the arbiter results
    modport master (
        output pst_req, req, req_addr, req_data,
        input  gnt, ack, en, d, pst, busy
    );

    // Arbiter side
    modport slave (
        input  pst_req, req, req_addr, req_data,
        output gnt, ack, en, d, pst, busy
    );
endinterface
`default_nettype wire

// File: rtl/reg_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reg_wr_arbiter
//  Purpose  : Round-robin write arbiter for a bank of R registers. Serialises
//             writes (WRITE then ACK), and runs a bank-wide preset that takes
//             priority over writes. Preset requests seen while busy are held
//             in a sticky flag. All state changes on the falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module reg_wr_arbiter #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    reg_wr_arbiter_if.slave bus
);

    // Requester index width; R is a power of two, so index arithmetic wraps
    // naturally modulo R.
    localparam int IW = $clog2(R);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WRITE  = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;
    localparam logic [1:0] S_PRESET = 2'd3;

    logic [1:0]    state_q,    state_d;
    logic [IW-1:0] rr_ptr_q,   rr_ptr_d;
    logic          pst_pend_q, pst_pend_d;
    logic [IW-1:0] win_q,      win_d;
    logic [1:0]    addr_q,     addr_d;
    logic [N-1:0]  data_q,     data_d;

    logic [R-1:0]  gnt_q,  gnt_d;
    logic [R-1:0]  ack_q,  ack_d;
    logic [R-1:0]  en_q,   en_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          pst_q,  pst_d;
    logic          busy_q, busy_d;

    logic [IW-1:0] scan_idx;
    logic [IW-1:0] win_idx;
    logic          win_found;

    // Winner search: first active request at or above rr_ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        scan_idx  = rr_ptr_q;
        for (int k = 0; k < R; k++) begin
            scan_idx = rr_ptr_q + IW'(k);
            if (!win_found && bus.req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Next-state logic; winner, address and data are captured on IDLE->WRITE
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        pst_pend_d = pst_pend_q;
        win_d      = win_q;
        addr_d     = addr_q;
        data_d     = data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.pst_req || pst_pend_q) begin
                    state_d    = S_PRESET;
                    pst_pend_d = 1'b0;
                end else if (win_found) begin
                    state_d = S_WRITE;
                    win_d   = win_idx;
                    addr_d  = bus.req_addr[2*win_idx +: 2];
                    data_d  = bus.req_data[N*win_idx +: N];
                end
            end
            S_WRITE: begin
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d  = S_IDLE;
                rr_ptr_d = win_q + IW'(1);
            end
            S_PRESET: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A preset asked for while busy is remembered until the next IDLE
        if ((state_q != S_IDLE) && bus.pst_req) begin
            pst_pend_d = 1'b1;
        end
    end

    // Output decode from the upcoming state so every output is a register
    always_comb begin
        gnt_d  = '0;
        ack_d  = '0;
        en_d   = '0;
        dout_d = dout_q;
        pst_d  = (state_d == S_PRESET);
        busy_d = (state_d != S_IDLE);
        if (state_d == S_WRITE) begin
            gnt_d[win_d]  = 1'b1;
            en_d[addr_d]  = 1'b1;
            dout_d        = data_d;
        end
        if (state_d == S_ACK) begin
            ack_d[win_d] = 1'b1;
        end
    end

    // State and output registers, falling edge, asynchronous active-low reset
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            pst_pend_q <= 1'b0;
            win_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            en_q       <= '0;
            dout_q     <= '0;
            pst_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            pst_pend_q <= pst_pend_d;
            win_q      <= win_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            en_q       <= en_d;
            dout_q     <= dout_d;
            pst_q      <= pst_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.ack  = ack_q;
    assign bus.en   = en_q;
    assign bus.d    = dout_q;
    assign bus.pst  = pst_q;
    assign bus.busy = busy_q;

endmodule
`default_nettype wire
